// File: rtl/mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_unit_if
// Description : Request / RAM-bus / response bundle of the load-store unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    logic        rsp_valid_o;
    logic        rsp_reg_wr_en_o;
    logic [4:0]  rsp_reg_wr_addr_o;
    logic [31:0] rsp_reg_wr_data_o;
    logic        rsp_err_o;
    logic        hold_flag_o;

    // slave: the memory unit itself
    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, req_rd_i, bus_ack_i, bus_rdata_i,
        output req_ready_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o,
               bus_wdata_o, rsp_valid_o, rsp_reg_wr_en_o, rsp_reg_wr_addr_o,
               rsp_reg_wr_data_o, rsp_err_o, hold_flag_o
    );

    // master: pipeline plus RAM environment driving the unit
    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, req_rd_i, bus_ack_i, bus_rdata_i,
        input  req_ready_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o,
               bus_wdata_o, rsp_valid_o, rsp_reg_wr_en_o, rsp_reg_wr_addr_o,
               rsp_reg_wr_data_o, rsp_err_o, hold_flag_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_unit
// Description : Single-outstanding load/store unit with byte-lane steering,
//               alignment checking and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_unit_if.slave  io
);

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state_q, w_state_d;
    logic        r_ready_q, w_ready_d;
    logic        r_hold_q, w_hold_d;
    logic [7:0]  r_tmo_q, w_tmo_d;

    logic        r_we_q, w_we_d;
    logic [1:0]  r_size_q, w_size_d;
    logic        r_uns_q, w_uns_d;
    logic [1:0]  r_lane_q, w_lane_d;
    logic [4:0]  r_rd_q, w_rd_d;

    logic        r_bus_req_q, w_bus_req_d;
    logic        r_bus_we_q, w_bus_we_d;
    logic [31:0] r_bus_addr_q, w_bus_addr_d;
    logic [3:0]  r_bus_be_q, w_bus_be_d;
    logic [31:0] r_bus_wdata_q, w_bus_wdata_d;

    logic        r_rsp_valid_q, w_rsp_valid_d;
    logic        r_rsp_wr_en_q, w_rsp_wr_en_d;
    logic [4:0]  r_rsp_addr_q, w_rsp_addr_d;
    logic [31:0] r_rsp_data_q, w_rsp_data_d;
    logic        r_rsp_err_q, w_rsp_err_d;

    logic        w_accept;
    logic        w_req_bad;

    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   f_be = 4'b0001 << lane;
            2'b01:   f_be = lane[1] ? 4'b1100 : 4'b0011;
            default: f_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   f_wdata = {4{wdata[7:0]}};
            2'b01:   f_wdata = {2{wdata[15:0]}};
            default: f_wdata = wdata;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lane, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   f_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   f_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: f_load = word;
        endcase
    endfunction

    assign w_accept  = r_ready_q & io.req_valid_i;
    assign w_req_bad = (io.req_size_i == 2'b11) ||
                       (io.req_size_i == 2'b01 && io.req_addr_i[0]) ||
                       (io.req_size_i == 2'b10 && io.req_addr_i[1:0] != 2'b00);

    always_comb begin
        w_state_d     = r_state_q;
        w_tmo_d       = r_tmo_q;
        w_we_d        = r_we_q;
        w_size_d      = r_size_q;
        w_uns_d       = r_uns_q;
        w_lane_d      = r_lane_q;
        w_rd_d        = r_rd_q;
        w_bus_we_d    = r_bus_we_q;
        w_bus_addr_d  = r_bus_addr_q;
        w_bus_be_d    = r_bus_be_q;
        w_bus_wdata_d = r_bus_wdata_q;
        w_rsp_valid_d = 1'b0;
        w_rsp_wr_en_d = 1'b0;
        w_rsp_addr_d  = 5'd0;
        w_rsp_data_d  = 32'd0;
        w_rsp_err_d   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_we_d   = io.req_we_i;
                    w_size_d = io.req_size_i;
                    w_uns_d  = io.req_unsigned_i;
                    w_lane_d = io.req_addr_i[1:0];
                    w_rd_d   = io.req_rd_i;
                    if (w_req_bad) begin
                        w_state_d     = ST_RESP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_addr_d  = io.req_rd_i;
                    end else begin
                        w_state_d     = ST_BUS;
                        w_tmo_d       = 8'd0;
                        w_bus_we_d    = io.req_we_i;
                        w_bus_addr_d  = {io.req_addr_i[31:2], 2'b00};
                        w_bus_be_d    = f_be(io.req_size_i, io.req_addr_i[1:0]);
                        w_bus_wdata_d = f_wdata(io.req_size_i, io.req_wdata_i);
                    end
                end
            end
            ST_BUS: begin
                // ack on the last allowed cycle still counts as success
                if (io.bus_ack_i) begin
                    w_state_d     = ST_RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_addr_d  = r_rd_q;
                    if (!r_we_q) begin
                        w_rsp_wr_en_d = 1'b1;
                        w_rsp_data_d  = f_load(r_size_q, r_uns_q, r_lane_q, io.bus_rdata_i);
                    end
                end else if (r_tmo_q == C_TMO_LAST) begin
                    w_state_d     = ST_RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_addr_d  = r_rd_q;
                end else begin
                    w_tmo_d = r_tmo_q + 8'd1;
                end
            end
            ST_RESP: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // bus outputs read as zero whenever no access is in flight
        if (w_state_d != ST_BUS) begin
            w_bus_we_d    = 1'b0;
            w_bus_addr_d  = 32'd0;
            w_bus_be_d    = 4'd0;
            w_bus_wdata_d = 32'd0;
        end

        w_bus_req_d = (w_state_d == ST_BUS);
        w_hold_d    = (w_state_d != ST_IDLE);
        w_ready_d   = (w_state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state_q     <= ST_IDLE;
            r_ready_q     <= 1'b0;
            r_hold_q      <= 1'b0;
            r_tmo_q       <= 8'd0;
            r_we_q        <= 1'b0;
            r_size_q      <= 2'd0;
            r_uns_q       <= 1'b0;
            r_lane_q      <= 2'd0;
            r_rd_q        <= 5'd0;
            r_bus_req_q   <= 1'b0;
            r_bus_we_q    <= 1'b0;
            r_bus_addr_q  <= 32'd0;
            r_bus_be_q    <= 4'd0;
            r_bus_wdata_q <= 32'd0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_wr_en_q <= 1'b0;
            r_rsp_addr_q  <= 5'd0;
            r_rsp_data_q  <= 32'd0;
            r_rsp_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ready_q     <= w_ready_d;
            r_hold_q      <= w_hold_d;
            r_tmo_q       <= w_tmo_d;
            r_we_q        <= w_we_d;
            r_size_q      <= w_size_d;
            r_uns_q       <= w_uns_d;
            r_lane_q      <= w_lane_d;
            r_rd_q        <= w_rd_d;
            r_bus_req_q   <= w_bus_req_d;
            r_bus_we_q    <= w_bus_we_d;
            r_bus_addr_q  <= w_bus_addr_d;
            r_bus_be_q    <= w_bus_be_d;
            r_bus_wdata_q <= w_bus_wdata_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_wr_en_q <= w_rsp_wr_en_d;
            r_rsp_addr_q  <= w_rsp_addr_d;
            r_rsp_data_q  <= w_rsp_data_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    assign io.req_ready_o       = r_ready_q;
    assign io.hold_flag_o       = r_hold_q;
    assign io.bus_req_o         = r_bus_req_q;
    assign io.bus_we_o          = r_bus_we_q;
    assign io.bus_addr_o        = r_bus_addr_q;
    assign io.bus_be_o          = r_bus_be_q;
    assign io.bus_wdata_o       = r_bus_wdata_q;
    assign io.rsp_valid_o       = r_rsp_valid_q;
    assign io.rsp_reg_wr_en_o   = r_rsp_wr_en_q;
    assign io.rsp_reg_wr_addr_o = r_rsp_addr_q;
    assign io.rsp_reg_wr_data_o = r_rsp_data_q;
    assign io.rsp_err_o         = r_rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_unit
// Description : Self-checking bench for mem_unit: directed vector table,
//               reset sequences and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_unit;

    localparam int T = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_unit_if u_if ();

    mem_unit #(.TIMEOUT_CYCLES(T)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          ack_at;   // BUS cycle (1-based) carrying the ack, 0 = never
        bit          noise;    // toggle request inputs while waiting
        logic        e_err;
        int          e_bus;
        logic [31:0] e_baddr;
        logic [3:0]  e_be;
        logic [31:0] e_bwd;
        logic [31:0] e_data;
        logic        e_wen;
    } vec_t;

    typedef struct {
        int          n_bus;
        int          lat;
        logic [31:0] baddr;
        logic [31:0] bwd;
        logic [3:0]  be;
        logic        bwe;
        logic        stable;
        logic        hold_ok;
        logic        got_rsp;
        logic        err;
        logic [31:0] data;
        logic        wen;
        logic [4:0]  raddr;
        logic        one_cycle;
    } obs_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [4:0] rd,
                                input int ack_at, input bit noise, input logic e_err,
                                input int e_bus, input logic [31:0] e_baddr,
                                input logic [3:0] e_be, input logic [31:0] e_bwd,
                                input logic [31:0] e_data, input logic e_wen);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.rd = rd; v.ack_at = ack_at; v.noise = noise;
        v.e_err = e_err; v.e_bus = e_bus; v.e_baddr = e_baddr; v.e_be = e_be;
        v.e_bwd = e_bwd; v.e_data = e_data; v.e_wen = e_wen;
        return v;
    endfunction

    // Reference: derives everything from byte counts and shifts.
    function automatic vec_t ref_model(input logic we, input logic [1:0] size, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [31:0] rdata, input logic [4:0] rd,
                                       input int ack_at, input bit noise);
        vec_t   v;
        int     nbytes;
        int     lane;
        bit     misal;
        longint mask;
        longint val;
        v = mk(we, size, uns, addr, wdata, rdata, rd, ack_at, noise,
               1'b0, 0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0);
        nbytes = 1 << size;
        lane   = int'(addr % 4);
        misal  = (size == 2'd3) || ((lane % nbytes) != 0);
        if (misal) begin
            v.e_err = 1'b1;
            v.e_bus = 0;
            return v;
        end
        if (ack_at == 0 || ack_at > T) begin
            v.e_err = 1'b1;
            v.e_bus = T;
        end else begin
            v.e_bus = ack_at;
        end
        v.e_baddr = addr - 32'(lane);
        v.e_be    = 4'(((1 << nbytes) - 1) << lane);
        for (int i = 0; i < 4; i++)
            v.e_bwd[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
        if (!we && !v.e_err) begin
            mask = (64'd1 << (8 * nbytes)) - 1;
            val  = (longint'(rdata) >> (8 * lane)) & mask;
            if (!uns && nbytes < 4 && val[8*nbytes-1])
                val = val | ~mask;
            v.e_data = val[31:0];
            v.e_wen  = 1'b1;
        end
        return v;
    endfunction

    task automatic txn(input vec_t v, output obs_t o);
        o = '{default: '0};
        u_if.req_valid_i    = 1'b1;
        u_if.req_we_i       = v.we;
        u_if.req_size_i     = v.size;
        u_if.req_unsigned_i = v.uns;
        u_if.req_addr_i     = v.addr;
        u_if.req_wdata_i    = v.wdata;
        u_if.req_rd_i       = v.rd;
        @(posedge clk); #1;
        u_if.req_valid_i = 1'b0;
        o.lat = 1; o.stable = 1'b1; o.hold_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (u_if.rsp_valid_o) begin
                o.got_rsp = 1'b1;
                o.err     = u_if.rsp_err_o;
                o.data    = u_if.rsp_reg_wr_data_o;
                o.wen     = u_if.rsp_reg_wr_en_o;
                o.raddr   = u_if.rsp_reg_wr_addr_o;
                if (!u_if.hold_flag_o || u_if.req_ready_o) o.hold_ok = 1'b0;
                break;
            end
            if (!u_if.hold_flag_o || u_if.req_ready_o) o.hold_ok = 1'b0;
            u_if.bus_ack_i   = 1'b0;
            u_if.bus_rdata_i = $urandom;
            if (u_if.bus_req_o) begin
                o.n_bus++;
                if (o.n_bus == 1) begin
                    o.baddr = u_if.bus_addr_o; o.bwd = u_if.bus_wdata_o;
                    o.be    = u_if.bus_be_o;   o.bwe = u_if.bus_we_o;
                end else if (o.baddr !== u_if.bus_addr_o || o.bwd !== u_if.bus_wdata_o ||
                             o.be !== u_if.bus_be_o || o.bwe !== u_if.bus_we_o) begin
                    o.stable = 1'b0;
                end
                if (o.n_bus == v.ack_at) begin
                    u_if.bus_ack_i   = 1'b1;
                    u_if.bus_rdata_i = v.rdata;
                end
            end
            if (v.noise) begin
                u_if.req_valid_i = 1'($urandom_range(0, 1));
                u_if.req_addr_i  = $urandom;
                u_if.req_wdata_i = $urandom;
                u_if.req_we_i    = 1'($urandom_range(0, 1));
                u_if.req_size_i  = 2'($urandom_range(0, 3));
                u_if.req_rd_i    = 5'($urandom_range(0, 31));
            end
            @(posedge clk); #1;
            o.lat++;
        end
        u_if.bus_ack_i   = 1'b0;
        u_if.req_valid_i = 1'b0;
        if (o.got_rsp) begin
            @(posedge clk); #1;
            o.one_cycle = !u_if.rsp_valid_o && u_if.req_ready_o && !u_if.hold_flag_o &&
                          !u_if.rsp_err_o && !u_if.rsp_reg_wr_en_o;
        end
    endtask

    task automatic run_vec(input vec_t v);
        obs_t o;
        txn(v, o);
        chk("rsp_seen", 32'(o.got_rsp), 32'd1);
        chk("bus_cycles", o.n_bus, v.e_bus);
        chk("latency", o.lat, v.e_bus + 1);
        chk("rsp_err", 32'(o.err), 32'(v.e_err));
        chk("rsp_data", o.data, v.e_data);
        chk("rsp_wen", 32'(o.wen), 32'(v.e_wen));
        chk("rsp_rd", 32'(o.raddr), 32'(v.rd));
        chk("resp_one_cycle", 32'(o.one_cycle), 32'd1);
        chk("hold_ready", 32'(o.hold_ok), 32'd1);
        if (v.e_bus > 0) begin
            chk("bus_addr", o.baddr, v.e_baddr);
            chk("bus_be", 32'(o.be), 32'(v.e_be));
            chk("bus_wdata", o.bwd, v.e_bwd);
            chk("bus_we", 32'(o.bwe), 32'(v.we));
            chk("bus_stable", 32'(o.stable), 32'd1);
        end
    endtask

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit spurious;
        logic rdy_after;
        total = 0; bad = 0;
        rst_n = 1'b1;
        u_if.req_valid_i = 1'b0; u_if.req_we_i = 1'b0; u_if.req_size_i = 2'd0;
        u_if.req_unsigned_i = 1'b0; u_if.req_addr_i = 32'd0; u_if.req_wdata_i = 32'd0;
        u_if.req_rd_i = 5'd0; u_if.bus_ack_i = 1'b0; u_if.bus_rdata_i = 32'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(u_if.req_ready_o), 32'd0);
        chk("rst_bus_req", 32'(u_if.bus_req_o), 32'd0);
        chk("rst_bus_addr", u_if.bus_addr_o, 32'd0);
        chk("rst_bus_be", 32'(u_if.bus_be_o), 32'd0);
        chk("rst_rsp_valid", 32'(u_if.rsp_valid_o), 32'd0);
        chk("rst_rsp_data", u_if.rsp_reg_wr_data_o, 32'd0);
        chk("rst_hold", 32'(u_if.hold_flag_o), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(u_if.req_ready_o), 32'd1);

        // we sz uns addr wdata rdata rd ack noise | err bus baddr be bwd data wen
        tbl.push_back(mk(0,0,0,32'h103,0,32'h80AA55CC,3,1,0, 0,1,32'h100,4'b1000,0,32'hFFFFFF80,1));
        tbl.push_back(mk(1,1,0,32'h202,32'h0000BEEF,0,4,1,0, 0,1,32'h200,4'b1100,32'hBEEFBEEF,0,0));
        tbl.push_back(mk(0,2,0,32'h006,0,0,5,1,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,32'h012,0,32'h89AB1234,6,2,0, 0,2,32'h010,4'b1100,0,32'h000089AB,1));
        tbl.push_back(mk(0,1,0,32'h010,0,32'h0000F00D,7,3,0, 0,3,32'h010,4'b0011,0,32'hFFFFF00D,1));
        tbl.push_back(mk(0,0,1,32'h101,0,32'h80AA55CC,8,1,0, 0,1,32'h100,4'b0010,0,32'h00000055,1));
        tbl.push_back(mk(1,0,0,32'h003,32'h123456A5,0,9,1,0, 0,1,32'h000,4'b1000,32'hA5A5A5A5,0,0));
        tbl.push_back(mk(1,2,0,32'h008,32'hDEADBEEF,0,10,2,0, 0,2,32'h008,4'b1111,32'hDEADBEEF,0,0));
        tbl.push_back(mk(0,3,0,32'h000,0,0,11,1,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,32'h011,0,0,12,1,0, 1,0,0,0,0,0,0));
        tbl.push_back(mk(0,2,0,32'h040,0,32'hCAFEF00D,13,4,1, 0,4,32'h040,4'b1111,0,32'hCAFEF00D,1));
        tbl.push_back(mk(0,1,1,32'h010,0,0,14,0,0, 1,4,32'h010,4'b0011,0,0,0));
        tbl.push_back(mk(0,1,1,32'h010,0,32'h0000ABCD,15,4,0, 0,4,32'h010,4'b0011,0,32'h0000ABCD,1));
        tbl.push_back(mk(0,0,0,32'h002,0,32'h00800000,16,1,0, 0,1,32'h000,4'b0100,0,32'hFFFFFF80,1));
        tbl.push_back(mk(0,2,0,32'h044,0,32'h11111111,17,5,0, 1,4,32'h044,4'b1111,0,0,0));
        foreach (tbl[i]) run_vec(tbl[i]);

        // reset asserted mid-access
        u_if.req_valid_i = 1'b1; u_if.req_we_i = 1'b0; u_if.req_size_i = 2'd2;
        u_if.req_addr_i = 32'h80; u_if.req_rd_i = 5'd20;
        @(posedge clk); #1;
        u_if.req_valid_i = 1'b0;
        chk("mid_bus_req", 32'(u_if.bus_req_o), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_bus_req", 32'(u_if.bus_req_o), 32'd0);
        chk("rst_mid_rsp_valid", 32'(u_if.rsp_valid_o), 32'd0);
        chk("rst_mid_hold", 32'(u_if.hold_flag_o), 32'd0);
        chk("rst_mid_ready", 32'(u_if.req_ready_o), 32'd0);
        rst_n = 1'b0;
        spurious = 1'b0;
        rdy_after = 1'b0;
        for (int c = 0; c < 4; c++) begin
            u_if.bus_ack_i = 1'b1;
            @(posedge clk); #1;
            if (c == 0) rdy_after = u_if.req_ready_o;
            if (u_if.rsp_valid_o || u_if.bus_req_o) spurious = 1'b1;
        end
        u_if.bus_ack_i = 1'b0;
        chk("rst_release_ready", 32'(rdy_after), 32'd1);
        chk("rst_no_spurious", 32'(spurious), 32'd0);
        run_vec(mk(0,2,0,32'h084,0,0,21,0,0, 1,T,32'h084,4'b1111,0,0,0));

        // randomized transactions against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_vec(ref_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), a, $urandom, $urandom,
                              5'($urandom_range(0, 31)), $urandom_range(0, 6),
                              1'($urandom_range(0, 1))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of BUS-state cycles to wait for bus_ack_i (legal range 2..255).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-high (1 = reset); the port name is kept per codebase convention.
REQ-004 req_valid_i  in  1  EX-stage memory request valid.
REQ-005 req_ready_o  out  1  unit can accept a request this cycle.
REQ-006 req_we_i  in  1  1 = store, 0 = load.
REQ-007 req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned_i  in  1  load zero-extend (LBU/LHU).
REQ-009 req_addr_i  in  32  byte address.
REQ-010 req_wdata_i  in  32  store data, right-aligned.
REQ-011 req_rd_i  in  5  load destination register.
REQ-012 bus_req_o  out  1  ram access strobe.
REQ-013 bus_we_o  out  1  ram write enable.
REQ-014 bus_addr_o  out  32  word-aligned address: {req_addr[31:2],2'b00}.
REQ-015 bus_be_o  out  4  byte enables.
REQ-016 bus_wdata_o  out  32  lane-replicated store data.
REQ-017 bus_ack_i  in  1  ram completion; ignored while bus_req_o=0.
REQ-018 bus_rdata_i  in  32  ram read word, valid when bus_ack_i=1.
REQ-019 rsp_valid_o  out  1  one-cycle completion pulse, no back-pressure.
REQ-020 rsp_reg_wr_en_o  out  1  write-back enable = rsp_valid & load & ~rsp_err.
REQ-021 rsp_reg_wr_addr_o  out  5  latched req_rd.
REQ-022 rsp_reg_wr_data_o  out  32  extended load data; 0 for stores and errors.
REQ-023 rsp_err_o  out  1  misaligned, illegal-size, or timeout fault.
REQ-024 hold_flag_o  out  1  pipeline stall request.

Function
REQ-025 The FSM SHALL have the states IDLE, BUS, and RESP; req_ready_o SHALL be 1 only in IDLE; hold_flag_o SHALL be 1 in BUS and RESP.
REQ-026 In IDLE, req_valid_i=1 SHALL latch all request fields at the edge; an aligned, legal request SHALL go to BUS, and any other request SHALL go to RESP with the error latched.
REQ-027 The misalignment rules SHALL be: half with addr[0]=1; word with addr[1:0]!=0; size 11 always illegal.
REQ-028 Errored requests SHALL NOT raise bus_req_o.
REQ-029 In BUS, bus_req_o SHALL be 1, and bus_addr/we/be/wdata SHALL remain stable until acknowledged.
REQ-030 bus_ack_i=1 in BUS SHALL capture bus_rdata_i, and the next state SHALL be RESP.
REQ-031 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-032 Store data SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-033 Load extraction SHALL be: byte from lane addr[1:0], half from lane addr[1], each sign- or zero-extended per req_unsigned; word passed through.
REQ-034 A timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-035 When the timeout counter reaches TIMEOUT_CYCLES-1 with no ack, the FSM SHALL drop bus_req_o and go to RESP with rsp_err_o=1.
REQ-036 An ack arriving on the final timeout cycle SHALL take priority over the timeout.
REQ-037 RESP SHALL last exactly one cycle: rsp_valid_o=1, then IDLE.
REQ-038 A new request SHALL NOT be accepted in the same cycle as RESP.
REQ-039 Latency SHALL be: request accepted at edge N; bus_req_o high from cycle N+1; ack in cycle N+k; rsp_valid_o in cycle N+k+1.
REQ-040 Minimum turnaround SHALL be 3 cycles per access.
REQ-041 rsp_* outputs SHALL be registered and SHALL be 0 outside RESP.

Reset
REQ-042 While rst_n=1, the FSM SHALL be IDLE and every output SHALL be 0, except req_ready_o, which SHALL be 0 during reset and 1 on the first cycle after reset.
REQ-043 Reset asserted in BUS or RESP SHALL drop bus_req_o at the next edge, suppress any pending rsp_valid_o, and clear the timeout counter.

Verification
REQ-044 LB addr 0x103, ram word 0x80AA55CC, ack on the first BUS cycle -> bus_be_o=0001 is not expected; bus_be_o=1000, rsp_reg_wr_data_o=0xFFFFFF80, rsp_valid_o two cycles after acceptance.
REQ-045 SH addr 0x202, wdata 0x0000BEEF -> bus_addr_o=0x200, bus_be_o=1100, bus_wdata_o=0xBEEFBEEF, rsp_reg_wr_en_o=0.
REQ-046 LW addr 0x006 -> no bus_req_o, next cycle rsp_valid_o=1 with rsp_err_o=1 and rsp_reg_wr_en_o=0.
REQ-047 LHU addr 0x10 with no ack, TIMEOUT_CYCLES=4 -> bus_req_o high for 4 cycles, then rsp_err_o=1; ack on the 4th cycle -> no error.
REQ-048 LW with ack after 3 wait cycles -> hold_flag_o high continuously, bus outputs stable, and req_valid_i pulses during BUS ignored.
REQ-049 rst_n pulsed during BUS -> bus_req_o=0 next cycle, no rsp_valid_o, req_ready_o=1 after reset releases.
